prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter DIV_W, default 28, prescaler width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, counter width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes prescaler and counter.
REQ-006 SHALL have port div_max  input  DIV_W  prescaler terminal value; tick period = div_max+1 cycles.
REQ-007 SHALL have port mod_max  input  CNT_W  counter terminal value; count range 0..mod_max.
REQ-008 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port oneshot  input  1  mode: 0 = wrap, 1 = stop at terminal value.
REQ-010 SHALL have port load  input  1  synchronous load strobe.
REQ-011 SHALL have port load_val  input  CNT_W  value written to q on load.
REQ-012 SHALL have port q  output  CNT_W  registered count.
REQ-013 SHALL have port tick  output  1  one-cycle pulse, high in the cycle q shows a value updated by a prescaler tick.
REQ-014 SHALL have port tc  output  1  one-cycle pulse, high in the cycle q shows a wrap or stop value.
REQ-015 SHALL have port done  output  1  one-shot completion flag, level.
REQ-016 SHALL have port div_clk  output  1  square wave toggling on every tick; period 2*(div_max+1) cycles.

Function
REQ-017 Prescaler SHALL increment each enabled cycle and, when pre >= div_max, return to 0 and raise an internal tick; div_max=0 SHALL give a tick every enabled cycle.
REQ-018 A lowered div_max with pre already above it SHALL tick on the next enabled cycle (>= compare; no 2^DIV_W overrun).
REQ-019 On an internal tick in up mode, q SHALL become q+1, or 0 when q >= mod_max; tc SHALL assert when 0 is taken.
REQ-020 On an internal tick in down mode, q SHALL become q-1, or mod_max when q == 0 or q > mod_max; tc SHALL assert when mod_max is taken.
REQ-021 In one-shot mode, a tick that would wrap SHALL instead leave q at the terminal value (up: mod_max; down: 0); it SHALL set done and pulse tc once.
REQ-022 While done=1, prescaler and counter SHALL hold, and tick, tc and div_clk SHALL stay static.
REQ-023 load SHALL override en and any tick: q<=load_val, pre<=0, done<=0; tick and tc SHALL stay 0 that cycle.
REQ-024 en=0 SHALL hold pre, q, done and div_clk; tick and tc SHALL be 0.
REQ-025 Clearing oneshot while done=1 SHALL clear done on the next cycle and resume counting.
REQ-026 Changing up_dn or mod_max SHALL take effect on the next tick without glitching q.
REQ-027 All outputs SHALL be registered; no derived clock SHALL drive any flop (div_clk is data only).

Reset
REQ-028 rst=0 SHALL immediately force pre=0, q=0, tick=0, tc=0, done=0 and div_clk=0, regardless of clk.
REQ-029 After rst deasserts, the first tick SHALL occur div_max+1 enabled cycles later.

Structure
REQ-030 A shared package prescaled_counter_pkg SHALL hold the direction constants (DIR_UP, DIR_DN) and the mode constants (MODE_WRAP, MODE_ONESHOT).
REQ-031 The prescaler SHALL be a sub-module tick_prescaler (parameter DIV_W; inputs clk, rst, en, clr, div_max; output tick).

Verification
REQ-032 DIV_W=4, CNT_W=3, div_max=3, mod_max=7, up, wrap, en=1 -> tick every 4 cycles; q 0..7 then 0 with tc=1; div_clk period 8 cycles.
REQ-033 mod_max=5, down, load_val=2 loaded -> q 2,1,0,5,4 on successive ticks; tc=1 on the cycle q=5.
REQ-034 oneshot=1, up, mod_max=3 from q=0 -> q reaches 3, done=1, tc single pulse; q stays 3 for 20 further cycles; load with load_val=0 -> done=0 and counting resumes.
REQ-035 div_max changed from 9 to 2 while pre=7 -> tick on the next cycle, then every 3 cycles.
REQ-036 load and tick in the same cycle -> q=load_val, tick=0, tc=0; en=0 for 5 cycles -> q and div_clk frozen.
REQ-037 rst asserted mid-count, off clock edge -> all outputs 0 immediately; after release, first tick after div_max+1 cycles.

Source files
------------

// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter: direction and mode encodings
// plus the classification of what a counter tick does to q.
package prescaled_counter_pkg;

  localparam logic DIR_DN       = 1'b0;
  localparam logic DIR_UP       = 1'b1;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic [1:0] {
    STEP_COUNT = 2'd0,  // ordinary increment/decrement
    STEP_WRAP  = 2'd1,  // rolled over to the opposite end of the range
    STEP_STOP  = 2'd2   // one-shot reached its terminal value
  } step_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts enabled cycles and flags the cycle in which
// the count has reached div_max, so the parent can act on that same edge.
module tick_prescaler #(
  parameter int DIV_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_max,
  output logic             tick
);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic             at_top;

  // >= rather than == so a div_max lowered below the running count still
  // fires immediately instead of waiting for the counter to overflow.
  assign at_top = (pre_q >= div_max);
  assign tick   = en && !clr && at_top;

  always_comb begin
    // NOTE: default assignment first so no path leaves pre_d unassigned (no latch).
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = at_top ? '0 : pre_q + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down modulo counter advanced by a prescaler tick, with wrap or one-shot
// behaviour, synchronous load and a data-only divided clock output.
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int DIV_W = 28,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_max,
  input  logic [CNT_W-1:0] mod_max,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             done,
  output logic             div_clk
);

  logic [CNT_W-1:0] q_q, q_d;
  logic             tick_q, tc_q, done_q, div_clk_q;
  logic             pre_tick;
  step_e            step;

  // A finished one-shot freezes the prescaler so resuming starts from a clean phase.
  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en && !done_q),
    .clr     (load),
    .div_max (div_max),
    .tick    (pre_tick)
  );

  // Next count for a tick; out-of-range values are treated as the wrap point.
  always_comb begin
    step = STEP_COUNT;
    q_d  = q_q;
    if (up_dn == DIR_UP) begin
      if (q_q >= mod_max) begin
        step = (oneshot == MODE_ONESHOT) ? STEP_STOP : STEP_WRAP;
        q_d  = (oneshot == MODE_ONESHOT) ? mod_max : '0;
      end else begin
        q_d  = q_q + CNT_W'(1);
      end
    end else begin
      if (q_q == '0 || q_q > mod_max) begin
        step = (oneshot == MODE_ONESHOT) ? STEP_STOP : STEP_WRAP;
        q_d  = (oneshot == MODE_ONESHOT) ? '0 : mod_max;
      end else begin
        q_d  = q_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      tick_q    <= 1'b0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      div_clk_q <= 1'b0;
    end else if (load) begin
      q_q    <= load_val;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else if (done_q) begin
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      if (oneshot == MODE_WRAP) done_q <= 1'b0;
    end else if (pre_tick) begin
      q_q       <= q_d;
      tick_q    <= 1'b1;
      tc_q      <= (step != STEP_COUNT);
      done_q    <= (step == STEP_STOP);
      div_clk_q <= ~div_clk_q;
    end else begin
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end
  end

  assign q       = q_q;
  assign tick    = tick_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign div_clk = div_clk_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter (DIV_W=4, CNT_W=3); expected values
// are hand-computed from the cycle-by-cycle prescaler and counter behaviour.
module tb_prescaled_counter;

  localparam int DIV_W = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_max;
  logic [CNT_W-1:0] mod_max;
  logic             up_dn;
  logic             oneshot;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] q;
  logic             tick;
  logic             tc;
  logic             done;
  logic             div_clk;

  int checks = 0;
  int errors = 0;

  prescaled_counter #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_max  (div_max),
    .mod_max  (mod_max),
    .up_dn    (up_dn),
    .oneshot  (oneshot),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tick     (tick),
    .tc       (tc),
    .done     (done),
    .div_clk  (div_clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".q"},       32'(q),       32'd0);
    check({tag, ".tick"},    32'(tick),    32'd0);
    check({tag, ".tc"},      32'(tc),      32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
    check({tag, ".div_clk"}, 32'(div_clk), 32'd0);
  endtask

  initial begin
    logic [CNT_W-1:0] exp_dn [4];
    logic             exp_tc_dn [4];
    int               bad;
    exp_dn    = '{3'd1, 3'd0, 3'd5, 3'd4};
    exp_tc_dn = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; en = 1'b1; div_max = 4'd3; mod_max = 3'd7;
    up_dn = 1'b1; oneshot = 1'b0; load = 1'b0; load_val = '0;
    #2;
    check_all_zero("reset_async");
    step(3);
    check_all_zero("reset_held");
    rst = 1'b1;

    // Up/wrap, tick every 4 cycles, q 1..7 then 0 with tc, div_clk toggles per tick.
    for (int k = 1; k <= 8; k++) begin
      step(3);
      check($sformatf("up_notick%0d", k), 32'(tick), 32'd0);
      step(1);
      check($sformatf("up_q%0d", k),    32'(q),       32'(k % 8));
      check($sformatf("up_tick%0d", k), 32'(tick),    32'd1);
      check($sformatf("up_tc%0d", k),   32'(tc),      32'(k == 8));
      check($sformatf("up_dclk%0d", k), 32'(div_clk), 32'(k % 2));
    end

    // en=0 for 5 cycles freezes everything, including the prescaler phase.
    step(2);
    en = 1'b0;
    step(5);
    check("freeze_q",    32'(q),       32'd0);
    check("freeze_tick", 32'(tick),    32'd0);
    check("freeze_dclk", 32'(div_clk), 32'd0);
    en = 1'b1;
    step(1);
    check("unfreeze_notick", 32'(tick), 32'd0);
    step(1);
    check("unfreeze_tick", 32'(tick),    32'd1);
    check("unfreeze_q",    32'(q),       32'd1);
    check("unfreeze_dclk", 32'(div_clk), 32'd1);

    // Load on the very cycle a tick would fire.
    step(3);
    load = 1'b1; load_val = 3'd5;
    step(1);
    load = 1'b0;
    check("ldtick_q",    32'(q),    32'd5);
    check("ldtick_tick", 32'(tick), 32'd0);
    check("ldtick_tc",   32'(tc),   32'd0);
    step(3);
    check("ldtick_notick", 32'(tick), 32'd0);
    step(1);
    check("ldtick_next_q", 32'(q), 32'd6);

    // Down mode from a loaded 2 with mod_max=5.
    mod_max = 3'd5; up_dn = 1'b0; load = 1'b1; load_val = 3'd2;
    step(1);
    load = 1'b0;
    check("dn_load_q", 32'(q), 32'd2);
    for (int k = 0; k < 4; k++) begin
      step(4);
      check($sformatf("dn_q%0d", k),  32'(q),  32'(exp_dn[k]));
      check($sformatf("dn_tc%0d", k), 32'(tc), 32'(exp_tc_dn[k]));
    end

    // Lowering div_max from 9 to 2 while pre=7.
    up_dn = 1'b1; mod_max = 3'd7; div_max = 4'd9; load = 1'b1; load_val = 3'd0;
    step(1);
    load = 1'b0;
    step(7);
    check("divchg_before", 32'(tick), 32'd0);
    div_max = 4'd2;
    step(1);
    check("divchg_tick", 32'(tick), 32'd1);
    check("divchg_q",    32'(q),    32'd1);
    step(2);
    check("divchg_gap", 32'(tick), 32'd0);
    step(1);
    check("divchg_tick2", 32'(tick), 32'd1);
    check("divchg_q2",    32'(q),    32'd2);

    // One-shot up to mod_max=3 with a tick every 2 cycles.
    div_max = 4'd1; mod_max = 3'd3; oneshot = 1'b1; load = 1'b1; load_val = 3'd0;
    step(1);
    load = 1'b0;
    step(6);
    check("os_reach_q",    32'(q),    32'd3);
    check("os_reach_done", 32'(done), 32'd0);
    step(2);
    check("os_stop_q",    32'(q),    32'd3);
    check("os_stop_done", 32'(done), 32'd1);
    check("os_stop_tc",   32'(tc),   32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (q !== 3'd3 || tc !== 1'b0 || tick !== 1'b0 || done !== 1'b1) bad++;
    end
    check("os_hold_bad_cycles", 32'(bad), 32'd0);
    load = 1'b1; load_val = 3'd0;
    step(1);
    load = 1'b0;
    check("os_reload_done", 32'(done), 32'd0);
    check("os_reload_q",    32'(q),    32'd0);
    step(2);
    check("os_resume_q", 32'(q), 32'd1);

    // Clearing oneshot while done resumes wrap counting.
    step(6);
    check("os2_done", 32'(done), 32'd1);
    oneshot = 1'b0;
    step(1);
    check("os_clear_done", 32'(done), 32'd0);
    check("os_clear_q",    32'(q),    32'd3);
    step(2);
    check("os_clear_wrap_q",  32'(q),  32'd0);
    check("os_clear_wrap_tc", 32'(tc), 32'd1);

    // Asynchronous reset mid-count, away from a clock edge.
    div_max = 4'd3;
    step(4);
    check("prerst_q", 32'(q), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #1;
    rst = 1'b1;
    step(3);
    check("rst_rel_notick", 32'(tick), 32'd0);
    step(1);
    check("rst_rel_tick", 32'(tick), 32'd1);
    check("rst_rel_q",    32'(q),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
